// File: rtl/red_pitaya_lpf_inverse_block.sv
// rtl/red_pitaya_lpf_inverse_block.sv - first-order low-pass inverse (lead) compensator
// x_hat[n] = y[n] + 2^k*(y[n]-y[n-1]), with settle passthrough on enable/shift change
module red_pitaya_lpf_inverse_block #(
    parameter int SHIFTBITS     = 4,
    parameter int SIGNALBITS    = 14,
    parameter int MAXSHIFT      = 14,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [SHIFTBITS:0]           shift,
    input  logic                         filter_on,
    input  logic signed [SIGNALBITS-1:0] signal_i,
    output logic signed [SIGNALBITS-1:0] signal_o,
    output logic                         sat_o,
    output logic                         settling_o
);

    localparam int SW = SIGNALBITS + MAXSHIFT + 2;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SHIFTBITS:0]           K_MAX      = (SHIFTBITS+1)'(MAXSHIFT);
    localparam logic [CW-1:0]                CNT_RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic signed [SIGNALBITS-1:0] OUT_MAX    = {1'b0, {(SIGNALBITS-1){1'b1}}};
    localparam logic signed [SIGNALBITS-1:0] OUT_MIN    = {1'b1, {(SIGNALBITS-1){1'b0}}};

    typedef enum logic [1:0] {S_BYPASS, S_SETTLE, S_RUN} state_t;

    state_t                         r_state, w_state_next;
    logic [SHIFTBITS:0]             r_k, w_k_next, w_k_req;
    logic [CW-1:0]                  r_cnt, w_cnt_next;
    logic signed [SIGNALBITS-1:0]   r_y_d1;
    logic signed [SIGNALBITS:0]     r_d1;
    logic signed [SW-1:0]           w_sum;
    logic                           w_k_changed;

    assign w_k_req     = (shift > K_MAX) ? K_MAX : shift;
    assign w_k_changed = (w_k_req != r_k);

    // Derivative term only in RUN; sum is wide enough that no shift overflows
    always_comb begin
        w_sum = SW'(r_y_d1);
        if (r_state == S_RUN)
            w_sum = w_sum + (SW'(r_d1) <<< r_k);
    end

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_cnt_next   = r_cnt;
        if (!filter_on) begin
            w_state_next = S_BYPASS;
        end else begin
            case (r_state)
                S_BYPASS: begin
                    w_state_next = S_SETTLE;
                    w_k_next     = w_k_req;
                    w_cnt_next   = CNT_RELOAD;
                end
                S_SETTLE: begin
                    if (w_k_changed) begin
                        w_k_next   = w_k_req;
                        w_cnt_next = CNT_RELOAD;
                    end else if (r_cnt == '0) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_cnt_next = r_cnt - CW'(1);
                    end
                end
                S_RUN: begin
                    if (w_k_changed) begin
                        w_state_next = S_SETTLE;
                        w_k_next     = w_k_req;
                        w_cnt_next   = CNT_RELOAD;
                    end
                end
                default: w_state_next = S_BYPASS;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_BYPASS;
            r_k        <= '0;
            r_cnt      <= '0;
            r_y_d1     <= '0;
            r_d1       <= '0;
            signal_o   <= '0;
            sat_o      <= 1'b0;
            settling_o <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_k        <= w_k_next;
            r_cnt      <= w_cnt_next;
            settling_o <= (w_state_next == S_SETTLE);
            r_y_d1     <= signal_i;
            r_d1       <= (SIGNALBITS+1)'(signal_i) - (SIGNALBITS+1)'(r_y_d1);
            if (w_sum > SW'(OUT_MAX)) begin
                signal_o <= OUT_MAX;
                sat_o    <= 1'b1;
            end else if (w_sum < SW'(OUT_MIN)) begin
                signal_o <= OUT_MIN;
                sat_o    <= 1'b1;
            end else begin
                signal_o <= w_sum[SIGNALBITS-1:0];
                sat_o    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_lpf_inverse_block.sv
// tb/tb_red_pitaya_lpf_inverse_block.sv - bench for red_pitaya_lpf_inverse_block
module tb_red_pitaya_lpf_inverse_block;

    localparam int SMAX = 8191;
    localparam int SMIN = -8192;
    localparam int KMAX = 14;
    localparam int NSET = 4;

    logic               clk_i;
    logic               rstn_i;
    logic [4:0]         shift;
    logic               filter_on;
    logic signed [13:0] signal_i;
    logic signed [13:0] signal_o;
    logic               sat_o;
    logic               settling_o;

    red_pitaya_lpf_inverse_block dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .shift      (shift),
        .filter_on  (filter_on),
        .signal_i   (signal_i),
        .signal_o   (signal_o),
        .sat_o      (sat_o),
        .settling_o (settling_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        int fon;
        int sh;
        int sig;
        int eo;
        int es;
        int est;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    // reference: engaged flag, remaining passthrough cycles, gain, last two inputs
    int m_active, m_left, m_k, m_ym1, m_ym2;
    int m_eo, m_es, m_est;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_left = 0; m_k = 0; m_ym1 = 0; m_ym2 = 0;
    endtask

    task automatic model_step(input int fon, input int sh, input int sig);
        longint s;
        int     req;
        s = m_ym1;
        if (m_active != 0 && m_left == 0)
            s = s + (longint'(m_ym1 - m_ym2) * (longint'(1) << m_k));
        if (s > SMAX)      begin m_eo = SMAX; m_es = 1; end
        else if (s < SMIN) begin m_eo = SMIN; m_es = 1; end
        else               begin m_eo = int'(s); m_es = 0; end
        req = (sh > KMAX) ? KMAX : sh;
        if (fon == 0) begin
            m_active = 0; m_left = 0;
        end else if (m_active == 0) begin
            m_active = 1; m_k = req; m_left = NSET;
        end else if (req != m_k) begin
            m_k = req; m_left = NSET;
        end else if (m_left > 0) begin
            m_left--;
        end
        m_est = (m_left > 0) ? 1 : 0;
        m_ym2 = m_ym1;
        m_ym1 = sig;
    endtask

    task automatic drive(input int fon, input int sh, input int sig);
        filter_on = fon[0];
        shift     = 5'(sh);
        signal_i  = 14'(sig);
        @(posedge clk_i);
        #1;
        model_step(fon, sh, sig);
    endtask

    task automatic add(input int fon, input int sh, input int sig,
                       input int eo, input int es, input int est);
        vec_t v;
        v.fon = fon; v.sh = sh; v.sig = sig; v.eo = eo; v.es = es; v.est = est;
        tbl.push_back(v);
    endtask

    initial begin
        int sh, sig, fon;
        model_reset();
        rstn_i = 1'b0; filter_on = 1'b1; shift = 5'd3; signal_i = 14'sd3000;
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("reset_out", int'(signal_o), 0);
        chk("reset_sat", int'(sat_o), 0);
        chk("reset_settle", int'(settling_o), 0);
        rstn_i = 1'b1;

        // bypass
        add(0, 0, 1000, 0, 0, 0);      add(0, 0, 1000, 1000, 0, 0);
        add(0, 0, 1000, 1000, 0, 0);
        // enable, shift 3, settle, then step 500->510
        add(1, 3, 500, 1000, 0, 1);    add(1, 3, 500, 500, 0, 1);
        add(1, 3, 500, 500, 0, 1);     add(1, 3, 500, 500, 0, 1);
        add(1, 3, 500, 500, 0, 0);     add(1, 3, 500, 500, 0, 0);
        add(1, 3, 510, 500, 0, 0);     add(1, 3, 510, 590, 0, 0);
        add(1, 3, 510, 510, 0, 0);
        // shift 10, saturation both ways
        add(1, 10, 0, 510, 0, 1);      add(1, 10, 0, 0, 0, 1);
        add(1, 10, 0, 0, 0, 1);        add(1, 10, 0, 0, 0, 1);
        add(1, 10, 0, 0, 0, 0);        add(1, 10, 0, 0, 0, 0);
        add(1, 10, 100, 0, 0, 0);      add(1, 10, 100, 8191, 1, 0);
        add(1, 10, 100, 100, 0, 0);    add(1, 10, -100, 100, 0, 0);
        add(1, 10, -100, -8192, 1, 0); add(1, 10, -100, -100, 0, 0);
        // shift change in RUN to 5, gain 32 afterwards
        add(1, 5, -100, -100, 0, 1);   add(1, 5, -100, -100, 0, 1);
        add(1, 5, -100, -100, 0, 1);   add(1, 5, -100, -100, 0, 1);
        add(1, 5, -100, -100, 0, 0);   add(1, 5, -90, -100, 0, 0);
        add(1, 5, -90, 230, 0, 0);     add(1, 5, -90, -90, 0, 0);
        // clamp: 20 -> 14 settles, 21 -> 14 does not
        add(1, 20, -90, -90, 0, 1);    add(1, 20, -90, -90, 0, 1);
        add(1, 20, -90, -90, 0, 1);    add(1, 20, -90, -90, 0, 1);
        add(1, 20, -90, -90, 0, 0);    add(1, 21, -90, -90, 0, 0);
        add(1, 21, -89, -90, 0, 0);    add(1, 21, -89, 8191, 1, 0);
        add(1, 21, -89, -89, 0, 0);
        // disable mid-settle
        add(1, 3, -89, -89, 0, 1);     add(0, 3, 200, -89, 0, 0);
        add(0, 3, 200, 200, 0, 0);     add(0, 3, 200, 200, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fon, tbl[i].sh, tbl[i].sig);
            chk($sformatf("vec%0d_out", i), int'(signal_o), tbl[i].eo);
            chk($sformatf("vec%0d_sat", i), int'(sat_o), tbl[i].es);
            chk($sformatf("vec%0d_settle", i), int'(settling_o), tbl[i].est);
        end

        sh = 3; sig = 0;
        for (int i = 0; i < 600; i++) begin
            fon = ($urandom_range(15) != 0) ? 1 : 0;
            if ($urandom_range(19) == 0) sh = $urandom_range(31);
            if ($urandom_range(3) == 0) begin
                sig = int'($urandom_range(16383)) - 8192;
            end else begin
                sig = sig + int'($urandom_range(200)) - 100;
                if (sig > SMAX) sig = SMAX;
                if (sig < SMIN) sig = SMIN;
            end
            drive(fon, sh, sig);
            chk($sformatf("rand%0d_out", i), int'(signal_o), m_eo);
            chk($sformatf("rand%0d_sat", i), int'(sat_o), m_es);
            chk($sformatf("rand%0d_settle", i), int'(settling_o), m_est);
        end

        // asynchronous reset mid-operation
        drive(1, 2, 4000);
        drive(1, 2, -4000);
        rstn_i = 1'b0;
        #1;
        chk("areset_out", int'(signal_o), 0);
        chk("areset_sat", int'(sat_o), 0);
        chk("areset_settle", int'(settling_o), 0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        model_reset();
        drive(1, 2, 3000);
        chk("post_reset_settle", int'(settling_o), 1);
        chk("post_reset_out", int'(signal_o), 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 2, 3000 + 5 * i);
            chk($sformatf("post%0d_out", i), int'(signal_o), m_eo);
            chk($sformatf("post%0d_settle", i), int'(settling_o), m_est);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
